// File: rtl/vmicro16_apb_uart_master.sv
// Debug APB initiator: decodes 'W' ah al dh dl / 'R' ah al byte commands from UART0,
// performs a single APB transfer and returns 'K', the read data, '?' or 'E' on tx.
module vmicro16_apb_uart_master #(
    parameter int BUS_WIDTH      = 16,
    parameter int DATA_WIDTH     = 16,
    parameter int PREADY_TIMEOUT = 255,
    parameter int BYTE_TIMEOUT   = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic [BUS_WIDTH-1:0]  M_PADDR,
    output logic                  M_PWRITE,
    output logic                  M_PSELx,
    output logic                  M_PENABLE,
    output logic [DATA_WIDTH-1:0] M_PWDATA,
    input  logic [DATA_WIDTH-1:0] M_PRDATA,
    input  logic                  M_PREADY,
    output logic                  overrun,
    output logic                  busy
);

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_BAD   = 8'h3F;
    localparam logic [7:0] RSP_ERR   = 8'h45;

    localparam int BT_W = $clog2(BYTE_TIMEOUT + 1);
    localparam int AT_W = $clog2(PREADY_TIMEOUT + 1);
    localparam logic [BT_W-1:0] BT_LAST = BT_W'(BYTE_TIMEOUT - 1);
    localparam logic [AT_W-1:0] AT_LAST = AT_W'(PREADY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE,
        ARGS,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t state, state_next;

    logic                  is_write;
    logic [1:0]            arg_cnt;
    logic [1:0]            arg_last;
    logic [BUS_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [BT_W-1:0]       byte_timer;
    logic [AT_W-1:0]       acc_timer;
    logic [7:0]            resp_b0;
    logic [7:0]            resp_b1;
    logic                  resp_idx;
    logic                  resp_last;
    logic                  known_cmd;
    logic                  accepting;

    assign known_cmd = (rx_data == CMD_WRITE) || (rx_data == CMD_READ);
    assign accepting = (state == IDLE) || (state == ARGS);
    assign arg_last  = is_write ? 2'd3 : 2'd1;

    assign M_PADDR   = addr;
    assign M_PWDATA  = wdata;
    assign M_PWRITE  = is_write;
    assign M_PSELx   = (state == SETUP) || (state == ACCESS);
    assign M_PENABLE = (state == ACCESS);
    assign tx_valid  = (state == RESP);
    assign tx_data   = tx_valid ? (resp_idx ? resp_b1 : resp_b0) : 8'h00;
    assign busy      = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: state_next is defaulted before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (rx_valid) state_next = known_cmd ? ARGS : RESP;
            end
            ARGS: begin
                if (rx_valid) begin
                    if (arg_cnt == arg_last) state_next = SETUP;
                end else if (byte_timer == BT_LAST) begin
                    state_next = IDLE;
                end
            end
            SETUP:  state_next = ACCESS;
            ACCESS: begin
                if (M_PREADY || (acc_timer == AT_LAST)) state_next = RESP;
            end
            RESP: begin
                if (tx_ready && (resp_idx == resp_last)) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            is_write   <= 1'b0;
            arg_cnt    <= 2'd0;
            addr       <= '0;
            wdata      <= '0;
            byte_timer <= '0;
            acc_timer  <= '0;
            resp_b0    <= 8'h00;
            resp_b1    <= 8'h00;
            resp_idx   <= 1'b0;
            resp_last  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            // Bytes arriving while a transfer or response is in flight are lost.
            if (rx_valid && !accepting) overrun <= 1'b1;

            case (state)
                IDLE: begin
                    if (rx_valid) begin
                        arg_cnt    <= 2'd0;
                        byte_timer <= '0;
                        resp_idx   <= 1'b0;
                        if (known_cmd) begin
                            is_write <= (rx_data == CMD_WRITE);
                        end else begin
                            resp_b0   <= RSP_BAD;
                            resp_last <= 1'b0;
                        end
                    end
                end
                ARGS: begin
                    if (rx_valid) begin
                        byte_timer <= '0;
                        arg_cnt    <= arg_cnt + 2'd1;
                        if (!arg_cnt[1]) addr  <= {addr[BUS_WIDTH-9:0], rx_data};
                        else             wdata <= {wdata[DATA_WIDTH-9:0], rx_data};
                    end else begin
                        byte_timer <= byte_timer + BT_W'(1);
                    end
                end
                SETUP: begin
                    acc_timer <= '0;
                end
                ACCESS: begin
                    if (M_PREADY) begin
                        if (is_write) begin
                            resp_b0   <= RSP_OK;
                            resp_last <= 1'b0;
                        end else begin
                            resp_b0   <= M_PRDATA[DATA_WIDTH-1:DATA_WIDTH-8];
                            resp_b1   <= M_PRDATA[7:0];
                            resp_last <= 1'b1;
                        end
                    end else if (acc_timer == AT_LAST) begin
                        resp_b0   <= RSP_ERR;
                        resp_last <= 1'b0;
                    end else begin
                        acc_timer <= acc_timer + AT_W'(1);
                    end
                end
                RESP: begin
                    if (tx_ready && (resp_idx != resp_last)) resp_idx <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/vmicro16_apb_uart_master.md
Name: vmicro16_apb_uart_master

Overview:
- Debug/host APB initiator: decodes a byte-stream command protocol from the UART0 receiver and issues single APB read/write transfers as an additional master port into the SoC data interconnect.
- Returns a byte-stream response to the UART0 transmitter.
- Complements the existing APB responders (BRAM, peripherals). It lets a host load memory, poke registers and inspect state without any core running.

Parameters:
- BUS_WIDTH, 16, APB address width. Fixed at 16; sent as 2 bytes, MSB first.
- DATA_WIDTH, 16, APB data width. Fixed at 16; sent as 2 bytes, MSB first.
- PREADY_TIMEOUT, 255, max cycles spent in ACCESS waiting for M_PREADY before abort.
- BYTE_TIMEOUT, 65535, max idle cycles between command bytes before the partial command is discarded.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- rx_data  input  8  received byte from UART receiver
- rx_valid  input  1  one-cycle strobe, rx_data valid; no backpressure
- tx_data  output  8  response byte to UART transmitter
- tx_valid  output  1  tx_data valid; held until tx_ready
- tx_ready  input  1  transmitter accepts byte when tx_valid&tx_ready
- M_PADDR  output  16  APB address
- M_PWRITE  output  1  APB write
- M_PSELx  output  1  APB select
- M_PENABLE  output  1  APB enable
- M_PWDATA  output  16  APB write data
- M_PRDATA  input  16  APB read data
- M_PREADY  input  1  APB ready
- overrun  output  1  sticky: rx byte arrived while not accepting; cleared only by reset
- busy  output  1  high in any state except IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; byte counter 0; timers 0; overrun 0.
- Command set:
  - 'W' (0x57), ah, al, dh, dl: APB write; response 'K' (0x4B).
  - 'R' (0x52), ah, al: APB read; response dh, dl.
  - Any other first byte: response '?' (0x3F).
  - APB timeout: response 'E' (0x45).
- States: IDLE, ARGS, SETUP, ACCESS, RESP.
- IDLE: on rx_valid latch the command byte.
  - 'W' -> ARGS, need 4 bytes.
  - 'R' -> ARGS, need 2 bytes.
  - Otherwise load '?' -> RESP.
- ARGS: each rx_valid shifts the byte into the address (first 2 bytes) or write data (next 2), MSB first.
  - Byte timer resets on each byte.
  - Last byte received -> SETUP on the next cycle.
  - Byte timer reaching BYTE_TIMEOUT -> IDLE, no response.
- SETUP (exactly 1 cycle): M_PSELx=1, M_PENABLE=0, with M_PADDR, M_PWRITE and M_PWDATA valid -> ACCESS.
- ACCESS: M_PSELx=1, M_PENABLE=1; PADDR, PWRITE and PWDATA stable.
  - On M_PREADY: capture M_PRDATA on reads; deassert PSELx/PENABLE the next cycle; load the response -> RESP.
  - PREADY in the first ACCESS cycle gives a 2-cycle transfer.
  - Access timer reaching PREADY_TIMEOUT with no PREADY: deassert PSELx/PENABLE, load 'E' -> RESP.
  - M_PRDATA is ignored outside ACCESS&PREADY.
- RESP: present bytes in order on tx_data with tx_valid=1. Advance on tx_valid&tx_ready. After the last byte, tx_valid=0 -> IDLE.
  - tx_data/tx_valid must not change while tx_valid&!tx_ready.
- rx_valid in SETUP, ACCESS or RESP: byte dropped, overrun<=1.
- rx_valid in the same cycle as the IDLE return is dropped too. Accepting states are IDLE and ARGS only.
- M_PSELx and M_PENABLE are never high outside SETUP/ACCESS. PENABLE is never high without PSELx.
- Exactly one APB transfer per valid command.
- Reset mid-transfer: PSELx/PENABLE drop in the cycle after reset is sampled; no response is sent.

Test Plan:
- Write: 57 00 10 AB CD; slave PREADY on first ACCESS cycle -> one SETUP then one ACCESS with PADDR=0x0010, PWRITE=1, PWDATA=0xABCD; tx 0x4B.
- Read with wait states: 52 00 10; slave asserts PREADY after 3 ACCESS cycles with PRDATA=0x1234 -> PENABLE high 3 cycles, PWRITE=0; tx 0x12 then 0x34.
- tx backpressure: read returning 0xBEEF with tx_ready low 5 cycles -> tx_data=0xBE held stable with tx_valid=1 until accepted, then 0xEF.
- Bad command 0x41 -> no APB activity; tx 0x3F. Unresponsive slave (PREADY stuck 0) -> ACCESS lasts PREADY_TIMEOUT cycles, bus released; tx 0x45.
- Partial command 57 00 then silence for BYTE_TIMEOUT cycles -> back to IDLE, no APB activity, no tx; next command 52 00 00 executes normally.
- rx byte injected during ACCESS -> overrun=1 and stays 1, current transfer unaffected. Reset asserted during ACCESS -> PSELx/PENABLE 0, busy 0, overrun 0.
